// File: rtl/wu_fetch.sv
// -----------------------------------------------------------------------------
// wu_fetch - work-unit fetch sequencer.
//
// Takes a [start, end] program window from manager control and walks it one
// read per cycle into the WU instruction memory. The window may wrap around
// the end of memory. Decode back-pressure parks the walk in HOLD without
// losing or repeating an address. After the last read, DRAIN waits out the
// memory read latency before done is pulsed.
//
// Optional feature macro: WU_FETCH_LOOP_EN
//   defined   : mcntl__wuf__loop_count exists and the window is repeated
//               loop_count extra times back to back before draining.
//   undefined : one pass per start, no loop_count port.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef MGR_INSTRUCTION_MEMORY_DEPTH
`define MGR_INSTRUCTION_MEMORY_DEPTH 64
`endif
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE 5:0
`endif
`ifndef MGR_MGR_ID_RANGE
`define MGR_MGR_ID_RANGE 3:0
`endif

module wu_fetch #(
  parameter int MEM_DEPTH = `MGR_INSTRUCTION_MEMORY_DEPTH,
  parameter int RD_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic [`MGR_MGR_ID_RANGE]      sys__mgr__mgrId,
  input  logic                          mcntl__wuf__start,
  input  logic [`MGR_WU_ADDRESS_RANGE]  mcntl__wuf__start_addr,
  input  logic [`MGR_WU_ADDRESS_RANGE]  mcntl__wuf__end_addr,
`ifdef WU_FETCH_LOOP_EN
  input  logic [7:0]                    mcntl__wuf__loop_count,
`endif
  input  logic                          wud__wuf__stall,
  output logic [`MGR_WU_ADDRESS_RANGE]  wuf__wum__addr,
  output logic                          wuf__wum__read,
  output logic                          wuf__mcntl__busy,
  output logic                          wuf__mcntl__done,
  output logic                          wuf__mcntl__err
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int AW = $bits(mcntl__wuf__start_addr);
  // One extra bit so a full-memory window (len == MEM_DEPTH) fits.
  localparam int RW = $clog2(MEM_DEPTH) + 1;
  // Working width for window-length arithmetic (adds MEM_DEPTH before subtract).
  localparam int XW = RW + 1;
  // Drain counter must hold values 0..RD_LAT.
  localparam int DW = $clog2(RD_LAT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [AW-1:0] A_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] R_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0] R_ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_ONE   = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_DEPTH = XW'(MEM_DEPTH);
  localparam logic [XW-1:0] X_LAST  = XW'(MEM_DEPTH - 1);
  localparam logic [DW-1:0] D_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0] D_ONE   = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] D_LAT   = DW'(RD_LAT);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Next address, wrapping at MEM_DEPTH (which need not be a power of two).
  function automatic logic [AW-1:0] f_addr_inc(input logic [AW-1:0] a);
    logic [AW-1:0] v;
    if (XW'(a) >= X_LAST) begin
      v = A_ZERO;
    end else begin
      v = a + A_ONE;
    end
    return v;
  endfunction

  // Window length ((e - s) mod MEM_DEPTH) + 1; e < s means the window wraps.
  function automatic logic [RW-1:0] f_win_len(input logic [AW-1:0] s,
                                               input logic [AW-1:0] e);
    logic [XW-1:0] s_x;
    logic [XW-1:0] e_x;
    logic [XW-1:0] d_x;
    s_x = XW'(s);
    e_x = XW'(e);
    if (e_x >= s_x) begin
      d_x = e_x - s_x;
    end else begin
      d_x = (e_x + X_DEPTH) - s_x;
    end
    return RW'(d_x + X_ONE);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]              r_state;
  logic [AW-1:0]           r_addr;        // address currently on the memory port
  logic                    r_read;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [AW-1:0]           r_start;       // window start, for loop reloads
  logic [AW-1:0]           r_next;        // next address to issue
  logic [RW-1:0]           r_rem;         // reads of this pass not yet issued
  logic [RW-1:0]           r_len;         // window length, for loop reloads
  logic [DW-1:0]           r_drain;
  logic [7:0]              r_passes;      // extra passes still to run
  logic [`MGR_MGR_ID_RANGE] r_mgr_id;     // debug only

  // Next-state values
  logic [1:0]              w_state_nxt;
  logic [AW-1:0]           w_addr_nxt;
  logic                    w_read_nxt;
  logic                    w_busy_nxt;
  logic                    w_done_nxt;
  logic                    w_err_nxt;
  logic [AW-1:0]           w_start_nxt;
  logic [AW-1:0]           w_next_nxt;
  logic [RW-1:0]           w_rem_nxt;
  logic [RW-1:0]           w_len_nxt;
  logic [DW-1:0]           w_drain_nxt;
  logic [7:0]              w_passes_nxt;
  logic [`MGR_MGR_ID_RANGE] w_mgr_id_nxt;

  logic [RW-1:0]           w_new_len;
  logic [7:0]              w_loop_count;
  logic                    w_dbg_unused;

`ifdef WU_FETCH_LOOP_EN
  assign w_loop_count = mcntl__wuf__loop_count;
`else
  // Single pass: no extra passes are ever requested.
  assign w_loop_count = 8'd0;
`endif

  assign w_new_len = f_win_len(mcntl__wuf__start_addr, mcntl__wuf__end_addr);

  // The captured manager id is only kept for debug visibility.
  assign w_dbg_unused = ^r_mgr_id;

  // ---------------------------------------------------------------------------
  // Sequencer next-state and registered-output logic
  // ---------------------------------------------------------------------------
  // Next-state decode for the fetch FSM, address walk and handshake pulses.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_read_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    // Any start while busy (including the done cycle) is rejected.
    w_err_nxt    = mcntl__wuf__start & r_busy;
    w_start_nxt  = r_start;
    w_next_nxt   = r_next;
    w_rem_nxt    = r_rem;
    w_len_nxt    = r_len;
    w_drain_nxt  = r_drain;
    w_passes_nxt = r_passes;
    w_mgr_id_nxt = r_mgr_id;

    case (r_state)
      S_IDLE: begin
        if (r_busy) begin
          // Done cycle: still busy, so a start here was rejected above.
          w_busy_nxt = 1'b0;
        end else if (mcntl__wuf__start) begin
          // Accept: the first read goes out in the very next cycle.
          w_start_nxt  = mcntl__wuf__start_addr;
          w_len_nxt    = w_new_len;
          w_addr_nxt   = mcntl__wuf__start_addr;
          w_read_nxt   = 1'b1;
          w_busy_nxt   = 1'b1;
          w_mgr_id_nxt = sys__mgr__mgrId;
          w_drain_nxt  = D_ZERO;
          if (w_new_len != R_ONE) begin
            w_next_nxt   = f_addr_inc(mcntl__wuf__start_addr);
            w_rem_nxt    = w_new_len - R_ONE;
            w_passes_nxt = w_loop_count;
            w_state_nxt  = S_FETCH;
          end else if (w_loop_count != 8'd0) begin
            // One-entry window repeated: reload straight away.
            w_next_nxt   = mcntl__wuf__start_addr;
            w_rem_nxt    = w_new_len;
            w_passes_nxt = w_loop_count - 8'd1;
            w_state_nxt  = S_FETCH;
          end else begin
            w_rem_nxt    = R_ZERO;
            w_passes_nxt = 8'd0;
            w_state_nxt  = S_DRAIN;
          end
        end else begin
          w_busy_nxt = 1'b0;
        end
      end

      S_FETCH, S_HOLD: begin
        if (wud__wuf__stall) begin
          // Park: read low, address held, nothing consumed.
          w_state_nxt = S_HOLD;
        end else begin
          w_read_nxt = 1'b1;
          w_addr_nxt = r_next;
          if (r_rem != R_ONE) begin
            w_next_nxt  = f_addr_inc(r_next);
            w_rem_nxt   = r_rem - R_ONE;
            w_state_nxt = S_FETCH;
          end else if (r_passes != 8'd0) begin
            // End of window with passes left: wrap to start, no bubble.
            w_next_nxt   = r_start;
            w_rem_nxt    = r_len;
            w_passes_nxt = r_passes - 8'd1;
            w_state_nxt  = S_FETCH;
          end else begin
            // Final read of the final pass.
            w_rem_nxt   = R_ZERO;
            w_drain_nxt = D_ZERO;
            w_state_nxt = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Wait for the last read's data to leave memory; stall is ignored.
        if (r_drain == D_LAT) begin
          w_done_nxt  = 1'b1;
          w_drain_nxt = D_ZERO;
          w_state_nxt = S_IDLE;
        end else begin
          w_drain_nxt = r_drain + D_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low power-on reset.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      r_state  <= S_IDLE;
      r_addr   <= A_ZERO;
      r_read   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= A_ZERO;
      r_next   <= A_ZERO;
      r_rem    <= R_ZERO;
      r_len    <= R_ZERO;
      r_drain  <= D_ZERO;
      r_passes <= 8'd0;
      r_mgr_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_read   <= w_read_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_start  <= w_start_nxt;
      r_next   <= w_next_nxt;
      r_rem    <= w_rem_nxt;
      r_len    <= w_len_nxt;
      r_drain  <= w_drain_nxt;
      r_passes <= w_passes_nxt;
      r_mgr_id <= w_mgr_id_nxt;
    end
  end

  assign wuf__wum__addr   = r_addr;
  assign wuf__wum__read   = r_read;
  assign wuf__mcntl__busy = r_busy;
  assign wuf__mcntl__done = r_done;
  assign wuf__mcntl__err  = r_err;

endmodule

// File: tb/tb_wu_fetch.sv
// -----------------------------------------------------------------------------
// tb_wu_fetch - directed self-checking bench for wu_fetch (MEM_DEPTH=64,
// RD_LAT=2). Cycle 1 is the cycle right after the start edge; outputs are
// sampled and inputs driven on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef MGR_INSTRUCTION_MEMORY_DEPTH
`define MGR_INSTRUCTION_MEMORY_DEPTH 64
`endif
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE 5:0
`endif
`ifndef MGR_MGR_ID_RANGE
`define MGR_MGR_ID_RANGE 3:0
`endif

module tb_wu_fetch;

  localparam int AW     = 6;
  localparam int RD_LAT = 2;

  logic                         clk = 1'b0;
  logic                         reset_poweron;
  logic [`MGR_MGR_ID_RANGE]     mgr_id;
  logic                         start;
  logic [AW-1:0]                start_addr;
  logic [AW-1:0]                end_addr;
  logic [7:0]                   loop_count;
  logic                         stall;
  logic [AW-1:0]                addr;
  logic                         read;
  logic                         busy;
  logic                         done;
  logic                         err;

  int n_vec = 0;
  int n_err = 0;

  // Memory latency model: valid follows read by RD_LAT cycles.
  logic [1:0] vpipe = 2'b00;
  logic       valid;

  // Observations gathered over one window
  int            c_nread, c_first_rd, c_last_rd;
  int            c_nbusy, c_busy_last;
  int            c_ndone, c_done_cyc;
  int            c_nerr, c_err_first, c_err_last;
  int            c_first_vld, c_nvld_win;
  logic [AW-1:0] c_addr [$];

  always #5 clk = ~clk;

  always @(posedge clk) vpipe <= {vpipe[0], read};
  assign valid = vpipe[1];

  wu_fetch #(.MEM_DEPTH(64), .RD_LAT(RD_LAT)) dut (
    .clk                    (clk),
    .reset_poweron          (reset_poweron),
    .sys__mgr__mgrId        (mgr_id),
    .mcntl__wuf__start      (start),
    .mcntl__wuf__start_addr (start_addr),
    .mcntl__wuf__end_addr   (end_addr),
`ifdef WU_FETCH_LOOP_EN
    .mcntl__wuf__loop_count (loop_count),
`endif
    .wud__wuf__stall        (stall),
    .wuf__wum__addr         (addr),
    .wuf__wum__read         (read),
    .wuf__mcntl__busy       (busy),
    .wuf__mcntl__done       (done),
    .wuf__mcntl__err        (err)
  );

  // Called on a falling edge; returns on the falling edge of cycle 1.
  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic [7:0] lc);
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    loop_count = lc;
    mgr_id     = 4'h5;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Observe cycles 1..ncyc; stall high in [st_from,st_to]; extra starts at
  // cycles rej1/rej2; valids counted in [v_from,v_to].
  task automatic collect(input int ncyc, input int st_from, input int st_to,
                         input int rej1, input int rej2,
                         input int v_from, input int v_to);
    c_nread = 0; c_first_rd = 0; c_last_rd = 0;
    c_nbusy = 0; c_busy_last = 0;
    c_ndone = 0; c_done_cyc = 0;
    c_nerr = 0; c_err_first = 0; c_err_last = 0;
    c_first_vld = 0; c_nvld_win = 0;
    c_addr.delete();
    for (int c = 1; c <= ncyc; c++) begin
      if (read === 1'b1) begin
        c_addr.push_back(addr);
        c_nread++;
        if (c_first_rd == 0) c_first_rd = c;
        c_last_rd = c;
      end
      if (busy === 1'b1) begin
        c_nbusy++;
        c_busy_last = c;
      end
      if (done === 1'b1) begin
        c_ndone++;
        if (c_done_cyc == 0) c_done_cyc = c;
      end
      if (err === 1'b1) begin
        c_nerr++;
        if (c_err_first == 0) c_err_first = c;
        c_err_last = c;
      end
      if (valid === 1'b1) begin
        if (c_first_vld == 0) c_first_vld = c;
        if (c >= v_from && c <= v_to) c_nvld_win++;
      end
      stall = (c >= st_from) && (c <= st_to);
      start = (c == rej1) || (c == rej2);
      if (start) begin
        start_addr = 6'h30;
        end_addr   = 6'h35;
      end
      @(negedge clk);
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_poweron = 1'b0;
    start = 1'b0; stall = 1'b0; start_addr = 6'h00; end_addr = 6'h00;
    loop_count = 8'd0; mgr_id = 4'h0;
    repeat (3) @(negedge clk);
    n_vec++; if (read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", read); end
    n_vec++; if (addr !== 6'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    reset_poweron = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [AW-1:0] exp_a [4];
    exp_a = '{6'h10, 6'h11, 6'h12, 6'h13};
    pulse_start(6'h10, 6'h13, 8'd0);
    collect(12, 0, -1, 0, 0, 0, -1);
    n_vec++; if (c_nread != 4) begin n_err++; $display("FAIL basic_nread: got %0d want 4", c_nread); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL basic_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL basic_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (c_first_rd != 1) begin n_err++; $display("FAIL basic_first_rd: got %0d want 1", c_first_rd); end
    n_vec++; if (c_last_rd != 4) begin n_err++; $display("FAIL basic_last_rd: got %0d want 4", c_last_rd); end
    n_vec++; if (c_first_vld != 3) begin n_err++; $display("FAIL basic_first_valid: got %0d want 3", c_first_vld); end
    n_vec++; if (c_ndone != 1) begin n_err++; $display("FAIL basic_ndone: got %0d want 1", c_ndone); end
    n_vec++; if (c_done_cyc != 7) begin n_err++; $display("FAIL basic_done_cyc: got %0d want 7", c_done_cyc); end
    n_vec++; if (c_nbusy != 7) begin n_err++; $display("FAIL basic_nbusy: got %0d want 7", c_nbusy); end
    n_vec++; if (c_busy_last != 7) begin n_err++; $display("FAIL basic_busy_last: got %0d want 7", c_busy_last); end
    n_vec++; if (c_nerr != 0) begin n_err++; $display("FAIL basic_nerr: got %0d want 0", c_nerr); end
    n_vec++; if (addr !== 6'h13) begin n_err++; $display("FAIL basic_addr_hold: got %h want 13", addr); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a = '{6'h3E, 6'h3F, 6'h00, 6'h01};
    pulse_start(6'h3E, 6'h01, 8'd0);
    collect(12, 0, -1, 0, 0, 0, -1);
    n_vec++; if (c_nread != 4) begin n_err++; $display("FAIL wrap_nread: got %0d want 4", c_nread); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL wrap_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (c_ndone != 1) begin n_err++; $display("FAIL wrap_ndone: got %0d want 1", c_ndone); end
    n_vec++; if (c_done_cyc != 7) begin n_err++; $display("FAIL wrap_done_cyc: got %0d want 7", c_done_cyc); end
  endtask

  task automatic test_single();
    pulse_start(6'h05, 6'h05, 8'd0);
    collect(8, 0, -1, 0, 0, 0, -1);
    n_vec++; if (c_nread != 1) begin n_err++; $display("FAIL single_nread: got %0d want 1", c_nread); end
    n_vec++; if (c_addr.size() < 1 || c_addr[0] !== 6'h05) begin n_err++; $display("FAIL single_addr: got %0d reads want addr 05", c_addr.size()); end
    n_vec++; if (c_done_cyc != 4) begin n_err++; $display("FAIL single_done_cyc: got %0d want 4", c_done_cyc); end
    n_vec++; if (c_nbusy != 4) begin n_err++; $display("FAIL single_nbusy: got %0d want 4", c_nbusy); end
  endtask

  task automatic test_full_window();
    int bad;
    logic [AW-1:0] exp;
    pulse_start(6'h20, 6'h1F, 8'd0);
    collect(72, 0, -1, 0, 0, 0, -1);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      exp = 6'h20 + 6'(i);
      if (i >= c_addr.size() || c_addr[i] !== exp) bad++;
    end
    n_vec++; if (c_nread != 64) begin n_err++; $display("FAIL full_nread: got %0d want 64", c_nread); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_seq: got %0d wrong addrs want 0", bad); end
    n_vec++; if (c_last_rd != 64) begin n_err++; $display("FAIL full_last_rd: got %0d want 64", c_last_rd); end
    n_vec++; if (c_done_cyc != 67) begin n_err++; $display("FAIL full_done_cyc: got %0d want 67", c_done_cyc); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] exp_a [6];
    int gaps;
    exp_a = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
    pulse_start(6'h08, 6'h0D, 8'd0);
    collect(16, 2, 4, 0, 0, 3, 7);
    gaps = (c_last_rd - c_first_rd + 1) - c_nread;
    n_vec++; if (c_nread != 6) begin n_err++; $display("FAIL stall_nread: got %0d want 6", c_nread); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL stall_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL stall_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (gaps != 3) begin n_err++; $display("FAIL stall_gaps: got %0d want 3", gaps); end
    n_vec++; if (c_last_rd != 9) begin n_err++; $display("FAIL stall_last_rd: got %0d want 9", c_last_rd); end
    n_vec++; if (c_nvld_win != 2) begin n_err++; $display("FAIL stall_skid_valids: got %0d want 2", c_nvld_win); end
    n_vec++; if (c_done_cyc != 12) begin n_err++; $display("FAIL stall_done_cyc: got %0d want 12", c_done_cyc); end
  endtask

  task automatic test_reject();
    logic [AW-1:0] exp_a [4];
    exp_a = '{6'h20, 6'h21, 6'h22, 6'h23};
    pulse_start(6'h20, 6'h23, 8'd0);
    collect(12, 0, -1, 2, 7, 0, -1);
    n_vec++; if (c_nread != 4) begin n_err++; $display("FAIL reject_nread: got %0d want 4", c_nread); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL reject_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL reject_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (c_nerr != 2) begin n_err++; $display("FAIL reject_nerr: got %0d want 2", c_nerr); end
    n_vec++; if (c_err_first != 3) begin n_err++; $display("FAIL reject_err_first: got %0d want 3", c_err_first); end
    n_vec++; if (c_err_last != 8) begin n_err++; $display("FAIL reject_err_done_cyc: got %0d want 8", c_err_last); end
    n_vec++; if (c_done_cyc != 7) begin n_err++; $display("FAIL reject_done_cyc: got %0d want 7", c_done_cyc); end
    n_vec++; if (c_ndone != 1) begin n_err++; $display("FAIL reject_ndone: got %0d want 1", c_ndone); end
    n_vec++; if (c_nbusy != 7) begin n_err++; $display("FAIL reject_nbusy: got %0d want 7", c_nbusy); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] exp_a [3];
    exp_a = '{6'h04, 6'h05, 6'h06};
    pulse_start(6'h00, 6'h0F, 8'd0);
    collect(2, 0, -1, 0, 0, 0, -1);
    reset_poweron = 1'b0;
    @(negedge clk);
    n_vec++; if (read !== 1'b0) begin n_err++; $display("FAIL midrst_read: got %b want 0", read); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (addr !== 6'h00) begin n_err++; $display("FAIL midrst_addr: got %h want 00", addr); end
    reset_poweron = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(6'h04, 6'h06, 8'd0);
    collect(10, 0, -1, 0, 0, 0, -1);
    n_vec++; if (c_nread != 3) begin n_err++; $display("FAIL midrst_nread: got %0d want 3", c_nread); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL midrst_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL midrst_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (c_done_cyc != 6) begin n_err++; $display("FAIL midrst_done_cyc: got %0d want 6", c_done_cyc); end
  endtask

`ifdef WU_FETCH_LOOP_EN
  task automatic test_loop();
    logic [AW-1:0] exp_a [9];
    exp_a = '{6'h00, 6'h01, 6'h02, 6'h00, 6'h01, 6'h02, 6'h00, 6'h01, 6'h02};
    pulse_start(6'h00, 6'h02, 8'd2);
    collect(16, 0, -1, 0, 0, 0, -1);
    n_vec++; if (c_nread != 9) begin n_err++; $display("FAIL loop_nread: got %0d want 9", c_nread); end
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (i >= c_addr.size()) begin n_err++; $display("FAIL loop_addr%0d: missing want %h", i, exp_a[i]); end
      else if (c_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL loop_addr%0d: got %h want %h", i, c_addr[i], exp_a[i]); end
    end
    n_vec++; if (c_last_rd != 9) begin n_err++; $display("FAIL loop_last_rd: got %0d want 9", c_last_rd); end
    n_vec++; if (c_ndone != 1) begin n_err++; $display("FAIL loop_ndone: got %0d want 1", c_ndone); end
    n_vec++; if (c_done_cyc != 12) begin n_err++; $display("FAIL loop_done_cyc: got %0d want 12", c_done_cyc); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_single();
    test_full_window();
    test_stall();
    test_reject();
    test_reset_mid();
`ifdef WU_FETCH_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
